// File: rtl/sd_card_timer_ctrl.sv
// Avalon-MM master that programs, starts and services the SD card interval timer.
// Define SD_CARD_TIMER_CTRL_SNAP_EN to snapshot the counter on cancel and expose 'remaining'.
module sd_card_timer_ctrl #(
  parameter bit          CONTINUOUS = 1'b0,
  parameter int unsigned MIN_CYCLES = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             arm_valid,
  input  logic [31:0]      arm_cycles,
  output logic             arm_ready,
  input  logic             cancel,
  output logic             busy,
  output logic             timeout_o,
  output logic             cancel_done,
  output logic [CNT_W-1:0] timeout_count,
`ifdef SD_CARD_TIMER_CTRL_SNAP_EN
  output logic [31:0]      remaining,
`endif
  output logic [2:0]       tmr_address,
  output logic             tmr_chipselect,
  output logic             tmr_write_n,
  output logic [15:0]      tmr_writedata,
  input  logic [15:0]      tmr_readdata,
  input  logic             tmr_irq
);

  // state    | meaning
  // IDLE     | waiting for an arm request
  // WR_PL    | write period_l
  // WR_PH    | write period_h
  // WR_ST    | clear stale timeout in status
  // WR_CTL   | start timer with irq enabled
  // WAIT     | timer running; watch irq and cancel
  // ACK_ST   | acknowledge irq, report timeout
  // STOP_CTL | stop timer, irq disabled
  // CLR_ST   | clear status after cancel
  // SNAP_*   | capture and read back the counter snapshot (optional)
  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_PL,
    S_WR_PH,
    S_WR_ST,
    S_WR_CTL,
    S_WAIT,
    S_ACK_ST,
    S_STOP_CTL,
`ifdef SD_CARD_TIMER_CTRL_SNAP_EN
    S_SNAP_WR,
    S_SNAP_RL,
    S_SNAP_RH,
    S_SNAP_CAP,
`endif
    S_CLR_ST
  } state_t;

  localparam logic [31:0] MIN_C     = 32'(MIN_CYCLES);
  localparam logic [15:0] CTL_START = CONTINUOUS ? 16'h0007 : 16'h0005;
  localparam logic [15:0] CTL_STOP  = 16'h0008;

  state_t             state_q, state_d;
  logic [31:0]        len_q, len_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cxl_q, cxl_d;
  logic               arm_ready_q, arm_ready_d;
  logic               busy_q, busy_d;
  logic               to_q, to_d;
  logic               cdone_q, cdone_d;
  logic               cs_q, cs_d;
  logic               wn_q, wn_d;
  logic [2:0]         addr_q, addr_d;
  logic [15:0]        wd_q, wd_d;
  logic [31:0]        arm_len;

`ifdef SD_CARD_TIMER_CTRL_SNAP_EN
  logic [15:0]        snap_lo_q, snap_lo_d;
  logic [15:0]        snap_hi_q, snap_hi_d;
  logic [31:0]        remaining_q, remaining_d;
  assign remaining = remaining_q;
`else
  logic               unused_rd;
  assign unused_rd = ^tmr_readdata;
`endif

  assign arm_len = (arm_cycles < MIN_C) ? MIN_C : arm_cycles;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    cxl_d   = cxl_q;
    to_d    = 1'b0;
    cdone_d = 1'b0;
`ifdef SD_CARD_TIMER_CTRL_SNAP_EN
    snap_lo_d   = snap_lo_q;
    snap_hi_d   = snap_hi_q;
    remaining_d = remaining_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (arm_valid && arm_ready_q) begin
          len_d   = arm_len - 32'd1;
          state_d = S_WR_PL;
        end
      end
      S_WR_PL:  state_d = S_WR_PH;
      S_WR_PH:  state_d = S_WR_ST;
      S_WR_ST:  state_d = S_WR_CTL;
      S_WR_CTL: state_d = S_WAIT;
      // irq has priority over a simultaneous cancel
      S_WAIT: begin
        if (tmr_irq) begin
          state_d = S_ACK_ST;
          to_d    = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
        end else if (cancel) begin
          state_d = S_STOP_CTL;
          cxl_d   = 1'b1;
        end
      end
      S_ACK_ST: begin
        if (CONTINUOUS) state_d = S_WAIT;
        else            state_d = S_STOP_CTL;
      end
      S_STOP_CTL: begin
        if (cxl_q) begin
`ifdef SD_CARD_TIMER_CTRL_SNAP_EN
          state_d = S_SNAP_WR;
`else
          state_d = S_CLR_ST;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
`ifdef SD_CARD_TIMER_CTRL_SNAP_EN
      S_SNAP_WR: state_d = S_SNAP_RL;
      S_SNAP_RL: state_d = S_SNAP_RH;
      // read data lags the read address by one cycle
      S_SNAP_RH: begin
        snap_lo_d = tmr_readdata;
        state_d   = S_SNAP_CAP;
      end
      S_SNAP_CAP: begin
        snap_hi_d = tmr_readdata;
        state_d   = S_CLR_ST;
      end
`endif
      S_CLR_ST: begin
        state_d = S_IDLE;
        cdone_d = 1'b1;
        cxl_d   = 1'b0;
`ifdef SD_CARD_TIMER_CTRL_SNAP_EN
        remaining_d = {snap_hi_q, snap_lo_q};
`endif
      end
      default: state_d = S_IDLE;
    endcase

    // bus outputs follow the state being entered so they line up with it
    cs_d   = 1'b0;
    wn_d   = 1'b1;
    addr_d = 3'd0;
    wd_d   = 16'h0000;
    case (state_d)
      S_WR_PL:    begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd2; wd_d = len_d[15:0];  end
      S_WR_PH:    begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd3; wd_d = len_d[31:16]; end
      S_WR_ST:    begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd0; end
      S_WR_CTL:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd1; wd_d = CTL_START;    end
      S_ACK_ST:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd0; end
      S_STOP_CTL: begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd1; wd_d = CTL_STOP;     end
      S_CLR_ST:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd0; end
`ifdef SD_CARD_TIMER_CTRL_SNAP_EN
      S_SNAP_WR:  begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd4; end
      S_SNAP_RL:  begin cs_d = 1'b1; addr_d = 3'd4; end
      S_SNAP_RH:  begin cs_d = 1'b1; addr_d = 3'd5; end
`endif
      default: ;
    endcase
    arm_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      len_q       <= 32'd0;
      cnt_q       <= '0;
      cxl_q       <= 1'b0;
      arm_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      to_q        <= 1'b0;
      cdone_q     <= 1'b0;
      cs_q        <= 1'b0;
      wn_q        <= 1'b1;
      addr_q      <= 3'd0;
      wd_q        <= 16'h0000;
`ifdef SD_CARD_TIMER_CTRL_SNAP_EN
      snap_lo_q   <= 16'h0000;
      snap_hi_q   <= 16'h0000;
      remaining_q <= 32'd0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      cxl_q       <= cxl_d;
      arm_ready_q <= arm_ready_d;
      busy_q      <= busy_d;
      to_q        <= to_d;
      cdone_q     <= cdone_d;
      cs_q        <= cs_d;
      wn_q        <= wn_d;
      addr_q      <= addr_d;
      wd_q        <= wd_d;
`ifdef SD_CARD_TIMER_CTRL_SNAP_EN
      snap_lo_q   <= snap_lo_d;
      snap_hi_q   <= snap_hi_d;
      remaining_q <= remaining_d;
`endif
    end
  end

  assign arm_ready      = arm_ready_q;
  assign busy           = busy_q;
  assign timeout_o      = to_q;
  assign cancel_done    = cdone_q;
  assign timeout_count  = cnt_q;
  assign tmr_chipselect = cs_q;
  assign tmr_write_n    = wn_q;
  assign tmr_address    = addr_q;
  assign tmr_writedata  = wd_q;

endmodule

// File: tb/tb_sd_card_timer_ctrl.sv
// Bench for sd_card_timer_ctrl: one-shot (instance 0) and continuous (instance 1, 2-bit counter)
// controllers, each driving a behavioural interval-timer slave.
module tb_sd_card_timer_ctrl;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        arm_valid [2];
  logic [31:0] arm_cycles [2];
  logic        cancel [2];
  logic        arm_ready [2];
  logic        busy [2];
  logic        timeout_o [2];
  logic        cancel_done [2];
  logic [15:0] tc0;
  logic [1:0]  tc1;
  logic [2:0]  tmr_address [2];
  logic        tmr_chipselect [2];
  logic        tmr_write_n [2];
  logic [15:0] tmr_writedata [2];
  logic        tmr_irq [2];
`ifdef SD_CARD_TIMER_CTRL_SNAP_EN
  logic [31:0] remaining [2];
`endif

  // behavioural timer slave state
  logic        to_q [2];
  logic        ito_q [2];
  logic        cont_q [2];
  logic        run_q [2];
  logic [31:0] per_q [2];
  logic [31:0] ctr_q [2];
  logic [31:0] snap_q [2];
  logic [15:0] rd_q [2];

  assign tmr_irq[0] = to_q[0] & ito_q[0];
  assign tmr_irq[1] = to_q[1] & ito_q[1];

  sd_card_timer_ctrl #(.CONTINUOUS(1'b0), .MIN_CYCLES(2), .CNT_W(16)) u_dut0 (
    .clk(clk), .reset_n(reset_n),
    .arm_valid(arm_valid[0]), .arm_cycles(arm_cycles[0]), .arm_ready(arm_ready[0]),
    .cancel(cancel[0]), .busy(busy[0]), .timeout_o(timeout_o[0]),
    .cancel_done(cancel_done[0]), .timeout_count(tc0),
`ifdef SD_CARD_TIMER_CTRL_SNAP_EN
    .remaining(remaining[0]),
`endif
    .tmr_address(tmr_address[0]), .tmr_chipselect(tmr_chipselect[0]),
    .tmr_write_n(tmr_write_n[0]), .tmr_writedata(tmr_writedata[0]),
    .tmr_readdata(rd_q[0]), .tmr_irq(tmr_irq[0])
  );

  sd_card_timer_ctrl #(.CONTINUOUS(1'b1), .MIN_CYCLES(2), .CNT_W(2)) u_dut1 (
    .clk(clk), .reset_n(reset_n),
    .arm_valid(arm_valid[1]), .arm_cycles(arm_cycles[1]), .arm_ready(arm_ready[1]),
    .cancel(cancel[1]), .busy(busy[1]), .timeout_o(timeout_o[1]),
    .cancel_done(cancel_done[1]), .timeout_count(tc1),
`ifdef SD_CARD_TIMER_CTRL_SNAP_EN
    .remaining(remaining[1]),
`endif
    .tmr_address(tmr_address[1]), .tmr_chipselect(tmr_chipselect[1]),
    .tmr_write_n(tmr_write_n[1]), .tmr_writedata(tmr_writedata[1]),
    .tmr_readdata(rd_q[1]), .tmr_irq(tmr_irq[1])
  );

  // Interval timer: counts period..0, sets TO on reaching 0; TO set beats a same-cycle clear.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset_n) begin
        to_q[i] <= 1'b0; ito_q[i] <= 1'b0; cont_q[i] <= 1'b0; run_q[i] <= 1'b0;
        per_q[i] <= 32'd0; ctr_q[i] <= 32'd0; snap_q[i] <= 32'd0; rd_q[i] <= 16'h0;
      end else begin
        if (tmr_chipselect[i] && !tmr_write_n[i]) begin
          case (tmr_address[i])
            3'd0: to_q[i] <= 1'b0;
            3'd1: begin
              ito_q[i]  <= tmr_writedata[i][0];
              cont_q[i] <= tmr_writedata[i][1];
              if (tmr_writedata[i][3]) run_q[i] <= 1'b0;
              if (tmr_writedata[i][2]) begin
                run_q[i] <= 1'b1;
                ctr_q[i] <= per_q[i];
              end
            end
            3'd2: begin per_q[i][15:0]  <= tmr_writedata[i]; run_q[i] <= 1'b0; end
            3'd3: begin per_q[i][31:16] <= tmr_writedata[i]; run_q[i] <= 1'b0; end
            3'd4: snap_q[i] <= ctr_q[i];
            default: ;
          endcase
        end
        if (tmr_chipselect[i] && tmr_write_n[i])
          rd_q[i] <= (tmr_address[i] == 3'd4) ? snap_q[i][15:0] :
                     (tmr_address[i] == 3'd5) ? snap_q[i][31:16] : 16'h0;
        if (run_q[i]) begin
          if (ctr_q[i] == 32'd0) begin
            to_q[i]  <= 1'b1;
            ctr_q[i] <= per_q[i];
            if (!cont_q[i]) run_q[i] <= 1'b0;
          end else begin
            ctr_q[i] <= ctr_q[i] - 32'd1;
          end
        end
      end
    end
  end

  // bus / pulse monitor; entry = {cycle, 13'b0, address, data}
  longint unsigned cyc = 0;
  longint unsigned wq0[$];
  longint unsigned wq1[$];
  longint unsigned toq0[$];
  longint unsigned toq1[$];
  int tcnt0 = 0, tcnt1 = 0, cdc0 = 0, cdc1 = 0;

  always @(negedge clk) begin
    cyc <= cyc + 64'd1;
    if (tmr_chipselect[0] && !tmr_write_n[0])
      wq0.push_back({cyc[31:0], 13'd0, tmr_address[0], tmr_writedata[0]});
    if (tmr_chipselect[1] && !tmr_write_n[1])
      wq1.push_back({cyc[31:0], 13'd0, tmr_address[1], tmr_writedata[1]});
    if (timeout_o[0]) begin toq0.push_back(cyc); tcnt0 <= tcnt0 + 1; end
    if (timeout_o[1]) begin toq1.push_back(cyc); tcnt1 <= tcnt1 + 1; end
    if (cancel_done[0]) cdc0 <= cdc0 + 1;
    if (cancel_done[1]) cdc1 <= cdc1 + 1;
  end

  int errors = 0;
  int checks = 0;
  logic [18:0] exq[$];
  logic [15:0] exp_tc0 = 16'h0;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input longint unsigned obs, input longint unsigned exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int wq_size(input int d);
    return (d == 0) ? wq0.size() : wq1.size();
  endfunction

  function automatic longint unsigned wq_at(input int d, input int i);
    return (d == 0) ? wq0[i] : wq1[i];
  endfunction

  function automatic logic [31:0] clamp_len(input logic [31:0] n);
    return (n < 32'd2) ? 32'd1 : n - 32'd1;
  endfunction

  task automatic exp_arm(input logic [31:0] l, input bit cont);
    exq.delete();
    exq.push_back({3'd2, l[15:0]});
    exq.push_back({3'd3, l[31:16]});
    exq.push_back({3'd0, 16'h0000});
    exq.push_back({3'd1, cont ? 16'h0007 : 16'h0005});
  endtask

  task automatic exp_cancel_tail();
    exq.push_back({3'd1, 16'h0008});
`ifdef SD_CARD_TIMER_CTRL_SNAP_EN
    exq.push_back({3'd4, 16'h0000});
`endif
    exq.push_back({3'd0, 16'h0000});
  endtask

  task automatic check_seq(input int d, input int s);
    int n;
    longint unsigned e;
    n = wq_size(d) - s;
    chk("wr_count", 64'(n), 64'(exq.size()));
    for (int i = 0; i < exq.size() && i < n; i++) begin
      e = wq_at(d, s + i);
      chk("wr_seq", 64'(e[18:0]), 64'(exq[i]));
    end
  endtask

  task automatic arm(input int d, input logic [31:0] n);
    arm_cycles[d] = n;
    arm_valid[d]  = 1'b1;
    tick(1);
    arm_valid[d]  = 1'b0;
    chk("accepted", 64'(busy[d]), 64'd1);
  endtask

  task automatic wait_idle(input int d, input int budget);
    int k;
    k = 0;
    while (busy[d] !== 1'b0 && k < budget) begin
      tick(1);
      k++;
    end
    chk("idle_in_time", 64'(busy[d]), 64'd0);
    chk("ready_in_idle", 64'(arm_ready[d]), 64'd1);
  endtask

  task automatic run_expiry(input logic [31:0] n);
    int s, t, c;
    logic [31:0] l;
    longint unsigned lat, c_ctl;
    s = wq_size(0); t = tcnt0; c = cdc0; l = clamp_len(n);
    arm(0, n);
    wait_idle(0, int'(l) + 40);
    tick(2);
    exp_arm(l, 1'b0);
    exq.push_back({3'd0, 16'h0000});
    exq.push_back({3'd1, 16'h0008});
    check_seq(0, s);
    exp_tc0 = exp_tc0 + 16'd1;
    chk("timeout_pulses", 64'(tcnt0 - t), 64'd1);
    chk("no_cancel_done", 64'(cdc0 - c), 64'd0);
    chk("timeout_count", 64'(tc0), 64'(exp_tc0));
    if (wq_size(0) >= s + 4 && toq0.size() > 0) begin
      c_ctl = wq_at(0, s + 3) >> 32;
      lat = toq0[$] - c_ctl;
      chk("arm_back2back", c_ctl - (wq_at(0, s) >> 32), 64'd3);
      chk("timeout_latency", 64'(lat >= 64'(l) + 1 && lat <= 64'(l) + 4), 64'd1);
    end
  endtask

  task automatic run_cancel(input logic [31:0] n, input int k);
    int s, t, c;
    logic [31:0] l;
    s = wq_size(0); t = tcnt0; c = cdc0; l = clamp_len(n);
    arm(0, n);
    tick(4 + k);
    cancel[0] = 1'b1;
    wait_idle(0, 40);
    cancel[0] = 1'b0;
    tick(2);
    exp_arm(l, 1'b0);
    exp_cancel_tail();
    check_seq(0, s);
    chk("cancel_no_timeout", 64'(tcnt0 - t), 64'd0);
    chk("cancel_done_once", 64'(cdc0 - c), 64'd1);
    chk("timer_stopped", 64'(run_q[0]), 64'd0);
    chk("count_unchanged", 64'(tc0), 64'(exp_tc0));
`ifdef SD_CARD_TIMER_CTRL_SNAP_EN
    chk("remaining_window",
        64'(64'(remaining[0]) + 64'(k) + 7 >= 64'(l) && 64'(remaining[0]) + 64'(k) <= 64'(l) + 1), 64'd1);
`endif
  endtask

  initial begin
    int s, t, c, k;
    for (int i = 0; i < 2; i++) begin
      arm_valid[i] = 1'b0; arm_cycles[i] = 32'd0; cancel[i] = 1'b0;
    end
    reset_n = 1'b0;
    tick(3);
    chk("rst_arm_ready", 64'(arm_ready[0]), 64'd1);
    chk("rst_busy", 64'(busy[0]), 64'd0);
    chk("rst_timeout", 64'(timeout_o[0]), 64'd0);
    chk("rst_cancel_done", 64'(cancel_done[0]), 64'd0);
    chk("rst_count0", 64'(tc0), 64'd0);
    chk("rst_count1", 64'(tc1), 64'd0);
    chk("rst_cs", 64'(tmr_chipselect[0]), 64'd0);
    chk("rst_write_n", 64'(tmr_write_n[0]), 64'd1);
    chk("rst_addr", 64'(tmr_address[0]), 64'd0);
    chk("rst_wdata", 64'(tmr_writedata[0]), 64'd0);
    chk("rst_busy1", 64'(busy[1]), 64'd0);
    reset_n = 1'b1;
    tick(2);

    run_expiry(32'd100);
    run_expiry(32'd0);
    run_expiry(32'd1);
    run_cancel(32'h0001_2345, 20);

    // irq and cancel land in the same WAIT cycle; arm attempts while busy
    s = wq_size(0); t = tcnt0; c = cdc0;
    arm(0, 32'd30);
    tick(4);
    arm_cycles[0] = 32'd77;
    arm_valid[0]  = 1'b1;
    tick(3);
    arm_valid[0]  = 1'b0;
    k = 0;
    while (tmr_irq[0] !== 1'b1 && k < 100) begin tick(1); k++; end
    cancel[0] = 1'b1;
    chk("irq_seen", 64'(tmr_irq[0]), 64'd1);
    wait_idle(0, 20);
    cancel[0] = 1'b0;
    tick(3);
    chk("no_late_accept", 64'(busy[0]), 64'd0);
    exp_arm(32'd29, 1'b0);
    exq.push_back({3'd0, 16'h0000});
    exq.push_back({3'd1, 16'h0008});
    check_seq(0, s);
    exp_tc0 = exp_tc0 + 16'd1;
    chk("simul_timeout", 64'(tcnt0 - t), 64'd1);
    chk("simul_no_cdone", 64'(cdc0 - c), 64'd0);
    chk("simul_count", 64'(tc0), 64'(exp_tc0));

    for (int it = 0; it < 8; it++) begin
      if ($urandom_range(0, 1) == 1)
        run_cancel($urandom_range(60, 150), int'($urandom_range(1, 30)));
      else
        run_expiry($urandom_range(0, 60));
    end

    // continuous mode, five periods then cancel
    s = wq_size(1); t = tcnt1; c = cdc1;
    arm(1, 32'd50);
    k = 0;
    begin
      int p;
      p = 0;
      while (p < 5 && k < 600) begin
        tick(1);
        k++;
        if (timeout_o[1] === 1'b1) p++;
      end
    end
    cancel[1] = 1'b1;
    wait_idle(1, 40);
    cancel[1] = 1'b0;
    tick(2);
    chk("cont_pulses", 64'(tcnt1 - t), 64'd5);
    chk("cont_cdone", 64'(cdc1 - c), 64'd1);
    chk("cont_count_wrap", 64'(tc1), 64'(5 % 4));
    if (toq1.size() >= 5)
      for (int i = 1; i < 5; i++)
        chk("cont_period", toq1[i] - toq1[i-1], 64'd50);
    exp_arm(32'd49, 1'b1);
    for (int i = 0; i < 5; i++) exq.push_back({3'd0, 16'h0000});
    exp_cancel_tail();
    check_seq(1, s);
    tick(150);
    chk("cont_no_more_timeouts", 64'(tcnt1 - t), 64'd5);
    chk("cont_timer_stopped", 64'(run_q[1]), 64'd0);

    // reset in the middle of the arm sequence
    arm(0, 32'd40);
    tick(1);
    chk("in_wr_ph", 64'(tmr_address[0]), 64'd3);
    reset_n = 1'b0;
    tick(1);
    chk("mid_rst_busy", 64'(busy[0]), 64'd0);
    chk("mid_rst_ready", 64'(arm_ready[0]), 64'd1);
    chk("mid_rst_cs", 64'(tmr_chipselect[0]), 64'd0);
    chk("mid_rst_write_n", 64'(tmr_write_n[0]), 64'd1);
    chk("mid_rst_addr", 64'(tmr_address[0]), 64'd0);
    chk("mid_rst_wdata", 64'(tmr_writedata[0]), 64'd0);
    chk("mid_rst_count", 64'(tc0), 64'd0);
    reset_n = 1'b1;
    exp_tc0 = 16'h0;
    tick(1);
    run_expiry(32'd10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
